conv2d_psum_accum: RTL and testbench
====================================

# conv2d_psum_accum

Output-channel partial-sum accumulator placed directly downstream of the conv2d engine. It consumes the engine's per-pixel `o_valid`/`o_data` stream, one full output map per input-channel pass. It accumulates that stream across `i_num_ci` passes in an on-chip pixel buffer. On the last pass it adds a bias, optionally applies ReLU, saturates to 16-bit Q8.8 and emits the finished output map.

## Interface
- `DATA_WIDTH`, 16: stream and bias width, signed Q8.8.
- `ACC_WIDTH`, 24: width of each partial-sum buffer entry, signed Q16.8.
- `MAX_PIX`, 784: buffer depth, i.e. the maximum number of output pixels per map.

- `i_clk`  in  1  clock; everything is on the rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  one-cycle pulse; latches the configuration and begins a job; honoured only in IDLE.
- `i_num_pix`  in  10  output pixels per map (≤ `MAX_PIX`); sampled at `i_start`.
- `i_num_ci`  in  10  number of input-channel passes to accumulate; sampled at `i_start`.
- `i_bias`  in  16  signed Q8.8 bias; sampled at `i_start`.
- `i_relu`  in  1  1 = clamp negative results to 0; sampled at `i_start`.
- `i_valid`  in  1  input pixel strobe; connects to the conv engine's `o_valid`.
- `i_data`  in  16  signed Q8.8 partial result; connects to the conv engine's `o_data`.
- `o_valid`  out  1  final pixel valid, one cycle per pixel.
- `o_data`  out  16  final signed Q8.8 pixel.
- `o_busy`  out  1  high from the cycle after an accepted `i_start` until the cycle `o_done` is asserted, inclusive.
- `o_done`  out  1  one-cycle pulse marking job completion.

## Operation
- **States:**
  - IDLE: waits for `i_start`.
  - ACCUM: passes `0..i_num_ci-2`.
  - FINAL: pass `i_num_ci-1`.
  - The state returns to IDLE after the done pulse.
- **Transition on `i_start` in IDLE:**
  - ACCUM if `i_num_ci` ≥ 2.
  - FINAL if `i_num_ci` = 1.
  - If `i_num_pix` = 0 or `i_num_ci` = 0: no state change beyond IDLE; `o_done` pulses on the next cycle; no `o_valid` is produced.
- **Counters:**
  - `pix_cnt` runs 0..`i_num_pix`-1 and advances only on `i_valid`.
  - When `pix_cnt` wraps to 0, `ci_cnt` increments.
  - Entering the last pass moves the state to FINAL.
- **Per-pixel update:**
  - Let `a` = `i_data` sign-extended to `ACC_WIDTH`.
  - Pass 0: `buf[pix_cnt] <= a`. The prior contents are ignored, so the buffer needs no reset.
  - Passes 1..`i_num_ci`-2: `buf[pix_cnt] <= sat_acc(buf[pix_cnt] + a)`, where `sat_acc` saturates to the `ACC_WIDTH` signed range.
  - FINAL pass: compute `s = buf[pix_cnt] + a + sext(i_bias)`, with `buf` read as 0 when `i_num_ci` = 1.
    - Saturate `s` to the 16-bit range: [-32768, 32767], i.e. 0x8000..0x7FFF.
    - If ReLU is enabled and the result is negative, output 0.
    - Register the result to `o_data` with `o_valid`.
    - The buffer is not written.
- **Read-after-write hazard:** when `i_num_pix` = 1, back-to-back `i_valid` cycles hit the same entry. The just-written value must be forwarded; results must be identical with or without gaps between `i_valid` cycles.
- **Ignored inputs:**
  - `i_valid` in IDLE is ignored.
  - `i_start` outside IDLE is ignored.
  - The configuration is stable for the whole job, regardless of input changes after `i_start`.
- **Reset:** asserting `i_rst` at any point aborts the job and returns to IDLE. All in-flight data is discarded; buffer contents are don't-care.

## Timing
- **Reset values:** `o_valid`=0, `o_data`=0x0000, `o_busy`=0, `o_done`=0, state IDLE, counters 0.
- **Start:** `o_busy` rises one cycle after an accepted `i_start`. `i_valid` is accepted from that cycle onward.
- **Output latency:** 1 cycle. A FINAL-pass `i_valid` at edge N produces `o_valid` with `o_data` after edge N+1.
- **Done:** `o_done` is asserted in the same cycle as the last `o_valid` of the job. `o_busy` drops on the following cycle.
- **Throughput:** one pixel per cycle sustained, with no backpressure. Arbitrary idle gaps between `i_valid` cycles are legal.
- **Back-to-back jobs:** a new `i_start` is accepted the cycle after `o_busy` falls.

## Test plan
- **Single pass:** `num_pix`=4, `num_ci`=1, bias=0x0080, relu=0, inputs 0x0100, 0x0200, 0xFF00, 0x0000 -> `o_data` 0x0180, 0x0280, 0xFF80, 0x0080, each 1 cycle after its input; `o_done` with the 4th output.
- **Multi-pass, 6×6 map:** `num_pix`=36, `num_ci`=8, all inputs 0x0100, bias=0, with random `i_valid` gaps -> exactly 36 outputs, all 0x0800; `o_done` on the 36th output; then `o_busy`=0.
- **Saturation and forwarding:**
  - `num_pix`=1, `num_ci`=4, inputs 0x7000 back-to-back -> 0x7FFF.
  - Inputs 0x9000 ×4 with relu=0 -> 0x8000.
  - Same with relu=1 -> 0x0000.
- **Reset mid-job:** after 10 inputs of pass 1, pulse `i_rst` -> `o_valid`/`o_busy`/`o_done` go to 0 immediately. A fresh job (`num_pix`=4, `num_ci`=2, inputs 0x0100) then yields 0x0200 ×4, with no stale data.
- **Degenerate configuration and ignored strobes:**
  - `i_start` with `num_pix`=0 -> `o_done` pulse 1 cycle later, no `o_valid`.
  - `i_start` while busy has no effect.
  - `i_valid` in IDLE produces no output.

Source files
------------

// File: rtl/conv2d_psum_accum_if.sv
// rtl/conv2d_psum_accum_if.sv - configuration, pixel stream and status bundle for the psum accumulator
interface conv2d_psum_accum_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  i_start;
    logic [9:0]            i_num_pix;
    logic [9:0]            i_num_ci;
    logic [DATA_WIDTH-1:0] i_bias;
    logic                  i_relu;
    logic                  i_valid;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_valid;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_busy;
    logic                  o_done;

    modport slave (
        input  i_start, i_num_pix, i_num_ci, i_bias, i_relu, i_valid, i_data,
        output o_valid, o_data, o_busy, o_done
    );

    modport master (
        output i_start, i_num_pix, i_num_ci, i_bias, i_relu, i_valid, i_data,
        input  o_valid, o_data, o_busy, o_done
    );
endinterface

// File: rtl/conv2d_psum_accum.sv
// rtl/conv2d_psum_accum.sv - accumulates conv2d partial maps over input channels, adds bias, ReLU, Q8.8 saturation
module conv2d_psum_accum #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 24,
    parameter int MAX_PIX    = 784
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    conv2d_psum_accum_if.slave   bus
);
    localparam int CW = 10;
    localparam int FW = ACC_WIDTH + 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         pix_cnt_q, pix_cnt_d;
    logic [CW-1:0]         ci_cnt_q, ci_cnt_d;
    logic [CW-1:0]         num_pix_q, num_pix_d;
    logic [CW-1:0]         num_ci_q, num_ci_d;
    logic [DATA_WIDTH-1:0] bias_q, bias_d;
    logic                  relu_q, relu_d;
    logic                  o_valid_q, o_valid_d;
    logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [ACC_WIDTH-1:0]  pbuf [MAX_PIX];
    logic                  wr_en;
    logic [ACC_WIDTH-1:0]  wr_data;
    logic [ACC_WIDTH-1:0]  a_ext, rd_val, acc_sat;
    logic [ACC_WIDTH:0]    acc_sum;
    logic [FW-1:0]         fin_sum;
    logic                  fin_fits;
    logic [DATA_WIDTH-1:0] fin_sat, fin_res;
    logic                  last_pix;

    // Asynchronous buffer read sees the previous edge's write, so a 1-pixel map
    // with back-to-back strobes is forwarded without extra bypass logic.
    always_comb begin
        a_ext    = {{(ACC_WIDTH-DATA_WIDTH){bus.i_data[DATA_WIDTH-1]}}, bus.i_data};
        rd_val   = (num_ci_q == CW'(1)) ? '0 : pbuf[pix_cnt_q];
        acc_sum  = {rd_val[ACC_WIDTH-1], rd_val} + {a_ext[ACC_WIDTH-1], a_ext};
        if (acc_sum[ACC_WIDTH] != acc_sum[ACC_WIDTH-1])
            acc_sat = acc_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        else
            acc_sat = acc_sum[ACC_WIDTH-1:0];
        fin_sum  = {{2{rd_val[ACC_WIDTH-1]}}, rd_val} + {{2{a_ext[ACC_WIDTH-1]}}, a_ext}
                 + {{(FW-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q};
        fin_fits = (&fin_sum[FW-1:DATA_WIDTH-1]) | ~(|fin_sum[FW-1:DATA_WIDTH-1]);
        if (fin_fits)
            fin_sat = fin_sum[DATA_WIDTH-1:0];
        else
            fin_sat = fin_sum[FW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        fin_res  = (relu_q && fin_sat[DATA_WIDTH-1]) ? '0 : fin_sat;
        last_pix = (pix_cnt_q == num_pix_q - CW'(1));
    end

    always_comb begin
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        ci_cnt_d  = ci_cnt_q;
        num_pix_d = num_pix_q;
        num_ci_d  = num_ci_q;
        bias_d    = bias_q;
        relu_d    = relu_q;
        o_valid_d = 1'b0;
        o_data_d  = o_data_q;
        busy_d    = busy_q & ~done_q;
        done_d    = 1'b0;
        wr_en     = 1'b0;
        wr_data   = a_ext;
        case (state_q)
            S_IDLE: begin
                // busy_q still high here means the done cycle; a start then is too early
                if (bus.i_start && !busy_q) begin
                    num_pix_d = bus.i_num_pix;
                    num_ci_d  = bus.i_num_ci;
                    bias_d    = bus.i_bias;
                    relu_d    = bus.i_relu;
                    pix_cnt_d = '0;
                    ci_cnt_d  = '0;
                    busy_d    = 1'b1;
                    if (bus.i_num_pix == '0 || bus.i_num_ci == '0)
                        done_d = 1'b1;
                    else
                        state_d = (bus.i_num_ci == CW'(1)) ? S_FINAL : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (bus.i_valid) begin
                    wr_en   = 1'b1;
                    wr_data = (ci_cnt_q == '0) ? a_ext : acc_sat;
                    if (last_pix) begin
                        pix_cnt_d = '0;
                        ci_cnt_d  = ci_cnt_q + CW'(1);
                        if (ci_cnt_q + CW'(1) == num_ci_q - CW'(1))
                            state_d = S_FINAL;
                    end else begin
                        pix_cnt_d = pix_cnt_q + CW'(1);
                    end
                end
            end
            S_FINAL: begin
                if (bus.i_valid) begin
                    o_valid_d = 1'b1;
                    o_data_d  = fin_res;
                    if (last_pix) begin
                        pix_cnt_d = '0;
                        ci_cnt_d  = '0;
                        done_d    = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        pix_cnt_d = pix_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            pix_cnt_q <= '0;
            ci_cnt_q  <= '0;
            num_pix_q <= '0;
            num_ci_q  <= '0;
            bias_q    <= '0;
            relu_q    <= 1'b0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            ci_cnt_q  <= ci_cnt_d;
            num_pix_q <= num_pix_d;
            num_ci_q  <= num_ci_d;
            bias_q    <= bias_d;
            relu_q    <= relu_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en)
            pbuf[pix_cnt_q] <= wr_data;
    end

    assign bus.o_valid = o_valid_q;
    assign bus.o_data  = o_data_q;
    assign bus.o_busy  = busy_q;
    assign bus.o_done  = done_q;
endmodule

// File: tb/tb_conv2d_psum_accum.sv
// tb/tb_conv2d_psum_accum.sv - directed scoreboard bench for conv2d_psum_accum
module tb_conv2d_psum_accum;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   n_outputs = 0;
    bit   degen_ok = 1'b0;

    logic [15:0] exp_data[$];
    bit          exp_last[$];
    int          exp_cyc[$];
    logic [15:0] m_data;
    bit          m_last;
    int          m_cyc;

    conv2d_psum_accum_if bus ();

    conv2d_psum_accum dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.o_valid) begin
            n_outputs++;
            chk("out_expected", 32'(exp_data.size() != 0), 32'd1);
            if (exp_data.size() != 0) begin
                m_data = exp_data.pop_front();
                m_last = exp_last.pop_front();
                m_cyc  = exp_cyc.pop_front();
                chk("o_data", 32'(bus.o_data), 32'(m_data));
                chk("o_done", 32'(bus.o_done), 32'(m_last));
                chk("latency", 32'(cyc), 32'(m_cyc));
            end
        end else if (!rst && bus.o_done) begin
            chk("done_without_valid", 32'(degen_ok), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [9:0] np, input logic [9:0] nci, input logic [15:0] bias, input logic relu);
        bus.i_start   = 1'b1;
        bus.i_num_pix = np;
        bus.i_num_ci  = nci;
        bus.i_bias    = bias;
        bus.i_relu    = relu;
        tick();
        bus.i_start   = 1'b0;
        bus.i_num_pix = 10'($urandom);
        bus.i_num_ci  = 10'($urandom);
        bus.i_bias    = 16'($urandom);
        bus.i_relu    = 1'($urandom);
        chk("busy_after_start", 32'(bus.o_busy), 32'd1);
    endtask

    task automatic send(input logic [15:0] d, input bit has_out, input logic [15:0] expv, input bit last, input int gap);
        repeat (gap) tick();
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        if (has_out) begin
            exp_data.push_back(expv);
            exp_last.push_back(last);
            exp_cyc.push_back(cyc + 1);
        end
        tick();
        bus.i_valid = 1'b0;
        bus.i_data  = 16'($urandom);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.o_busy && n < 2000) begin
            tick();
            n++;
        end
        chk(tag, 32'(bus.o_busy), 32'd0);
        chk("scoreboard_empty", 32'(exp_data.size()), 32'd0);
        tick();
    endtask

    initial begin
        bus.i_start = 0; bus.i_num_pix = 0; bus.i_num_ci = 0; bus.i_bias = 0;
        bus.i_relu = 0; bus.i_valid = 0; bus.i_data = 0;
        repeat (3) tick();
        chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_o_data", 32'(bus.o_data), 32'd0);
        chk("rst_o_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_o_done", 32'(bus.o_done), 32'd0);
        rst = 1'b0;
        tick();

        // single pass with bias
        start_job(10'd4, 10'd1, 16'h0080, 1'b0);
        send(16'h0100, 1, 16'h0180, 0, 0);
        send(16'h0200, 1, 16'h0280, 0, 0);
        send(16'hFF00, 1, 16'hFF80, 0, 0);
        send(16'h0000, 1, 16'h0080, 1, 0);
        chk("single_done", 32'(bus.o_done), 32'd1);
        chk("single_busy_at_done", 32'(bus.o_busy), 32'd1);
        tick();
        chk("single_busy_fall", 32'(bus.o_busy), 32'd0);
        chk("single_done_fall", 32'(bus.o_done), 32'd0);
        wait_idle("single_idle");

        // 6x6 map, 8 passes, random gaps
        n_outputs = 0;
        start_job(10'd36, 10'd8, 16'h0000, 1'b0);
        for (int p = 0; p < 8; p++)
            for (int i = 0; i < 36; i++)
                send(16'h0100, p == 7, 16'h0800, (p == 7) && (i == 35),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        tick();
        wait_idle("map6x6_idle");
        chk("map6x6_count", 32'(n_outputs), 32'd36);

        // saturation with 1-pixel forwarding
        start_job(10'd1, 10'd4, 16'h0000, 1'b0);
        for (int i = 0; i < 4; i++) send(16'h7000, i == 3, 16'h7FFF, i == 3, 0);
        wait_idle("sat_pos_idle");
        start_job(10'd1, 10'd4, 16'h0000, 1'b0);
        for (int i = 0; i < 4; i++) send(16'h9000, i == 3, 16'h8000, i == 3, 0);
        wait_idle("sat_neg_idle");
        start_job(10'd1, 10'd4, 16'h0000, 1'b1);
        for (int i = 0; i < 4; i++) send(16'h9000, i == 3, 16'h0000, i == 3, 0);
        wait_idle("sat_relu_idle");
        start_job(10'd1, 10'd4, 16'h0000, 1'b0);
        for (int i = 0; i < 4; i++) send(16'h9000, i == 3, 16'h8000, i == 3, 2);
        wait_idle("sat_gap_idle");
        start_job(10'd1, 10'd3, 16'h0040, 1'b1);
        for (int i = 0; i < 3; i++) send(16'h0100, i == 2, 16'h0340, i == 2, 0);
        wait_idle("fwd_bias_idle");

        // reset in the middle of pass 1
        start_job(10'd16, 10'd3, 16'h0000, 1'b0);
        for (int i = 0; i < 26; i++) send(16'h0300, 0, 16'h0000, 0, 0);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(bus.o_busy), 32'd0);
        chk("midrst_valid", 32'(bus.o_valid), 32'd0);
        chk("midrst_done", 32'(bus.o_done), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        start_job(10'd4, 10'd2, 16'h0000, 1'b0);
        for (int i = 0; i < 4; i++) send(16'h0100, 0, 16'h0000, 0, 0);
        for (int i = 0; i < 4; i++) send(16'h0100, 1, 16'h0200, i == 3, 0);
        wait_idle("postrst_idle");

        // degenerate configurations
        degen_ok = 1'b1;
        start_job(10'd0, 10'd3, 16'h0000, 1'b0);
        chk("npix0_done", 32'(bus.o_done), 32'd1);
        chk("npix0_valid", 32'(bus.o_valid), 32'd0);
        tick();
        chk("npix0_done_fall", 32'(bus.o_done), 32'd0);
        tick();
        start_job(10'd5, 10'd0, 16'h0000, 1'b0);
        chk("nci0_done", 32'(bus.o_done), 32'd1);
        tick();
        degen_ok = 1'b0;
        wait_idle("degen_idle");

        // start while busy is ignored
        start_job(10'd2, 10'd1, 16'h0000, 1'b0);
        send(16'h0100, 1, 16'h0100, 0, 0);
        bus.i_start = 1'b1; bus.i_num_pix = 10'd1; bus.i_num_ci = 10'd1; bus.i_bias = 16'h1000;
        tick();
        bus.i_start = 1'b0;
        send(16'h0200, 1, 16'h0200, 1, 0);
        wait_idle("busy_start_idle");

        // strobes in idle produce nothing
        n_outputs = 0;
        for (int i = 0; i < 3; i++) send(16'h1234, 0, 16'h0000, 0, 0);
        repeat (3) tick();
        chk("idle_valid_outputs", 32'(n_outputs), 32'd0);
        chk("idle_busy", 32'(bus.o_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
